reorder_buffer: RTL and testbench

//  In-order commit end of the ROB_Entry path. Dispatch allocates up to DISP_WIDTH entries/cycle at tail.

---
 rtl/reorder_buffer_pkg.sv | 49 ++++
 rtl/rob_retire_select.sv | 54 +++++
 rtl/reorder_buffer.sv | 190 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer.
//   NUM_ROB_ENTS  entries in the ROB (power of two)
//   DISP_WIDTH    allocation lanes per cycle
//   RETIRE_WIDTH  retire lanes per cycle
//   NUM_FUS       completion ports, one per execution pipe
// Types: rob_idx_t (entry index), rob_cnt_t (occupancy 0..NUM_ROB_ENTS),
//        ROB_Entry (entry payload), ROB_Cmpl (one completion port).
package reorder_buffer_pkg;

    localparam int NUM_ROB_ENTS = 64;
    localparam int DISP_WIDTH   = 2;
    localparam int RETIRE_WIDTH = 4;
    localparam int NUM_FUS      = 4;

    localparam int RI       = $clog2(NUM_ROB_ENTS);
    localparam int AREG_W   = 5;
    localparam int PREG_W   = 7;
    localparam int PC_W     = 32;
    localparam int NRET_W   = $clog2(RETIRE_WIDTH + 1);
    localparam int NALLOC_W = $clog2(DISP_WIDTH + 1);
    localparam int LANE_W   = $clog2(RETIRE_WIDTH);

    typedef logic [RI-1:0]       rob_idx_t;
    typedef logic [RI:0]         rob_cnt_t;
    typedef logic [NRET_W-1:0]   ret_cnt_t;
    typedef logic [NALLOC_W-1:0] alloc_cnt_t;
    typedef logic [LANE_W-1:0]   ret_lane_t;

    typedef struct packed {
        logic [AREG_W-1:0] dst_areg;
        logic [PREG_W-1:0] dst_preg;
        logic [PC_W-1:0]   pc;
        logic              exception;
        logic              br_mispred;
    } ROB_Entry;

    typedef struct packed {
        logic     valid;
        rob_idx_t idx;
        logic     exception;
        logic     br_mispred;
    } ROB_Cmpl;

    // Index arithmetic wraps naturally because NUM_ROB_ENTS is a power of two.
    function automatic rob_idx_t rob_idx_add(input rob_idx_t base, input int unsigned off);
        return base + rob_idx_t'(off);
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Retire lane selection: scans RETIRE_WIDTH entries starting at head and
// decides which lanes retire this cycle.
//   head        oldest entry index
//   ent_valid   per-entry allocated bit
//   ent_done    per-entry completed bit
//   ent_exc     per-entry exception bit
//   ent_brm     per-entry branch-mispredict bit
//   ret_valid   retiring lanes, contiguous from lane 0
//   n_ret       number of retiring lanes
//   flush       a faulting entry retires this cycle
//   flush_lane  lane holding that faulting entry
module rob_retire_select
    import reorder_buffer_pkg::*;
(
    input  rob_idx_t                  head,
    input  logic [NUM_ROB_ENTS-1:0]   ent_valid,
    input  logic [NUM_ROB_ENTS-1:0]   ent_done,
    input  logic [NUM_ROB_ENTS-1:0]   ent_exc,
    input  logic [NUM_ROB_ENTS-1:0]   ent_brm,
    output logic [RETIRE_WIDTH-1:0]   ret_valid,
    output ret_cnt_t                  n_ret,
    output logic                      flush,
    output ret_lane_t                 flush_lane
);

    always_comb begin : scan
        logic     stop;
        rob_idx_t idx;
        ret_valid  = '0;
        n_ret      = '0;
        flush      = 1'b0;
        flush_lane = '0;
        stop       = 1'b0;
        idx        = head;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            idx = rob_idx_add(head, k);
            if (!stop) begin
                if (ent_valid[idx] && ent_done[idx]) begin
                    ret_valid[k] = 1'b1;
                    n_ret        = n_ret + ret_cnt_t'(1);
                    // A faulting entry is the last one allowed out this cycle.
                    if (ent_exc[idx] || ent_brm[idx]) begin
                        flush      = 1'b1;
                        flush_lane = ret_lane_t'(k);
                        stop       = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries at tail on dispatch, marks them done on
// completion, and retires done entries in order from head. A retiring
// faulting entry (exception or branch mispredict) flushes the whole buffer.
//   clk, rst          clock; synchronous active-high reset
//   disp_valid        per-lane allocate request (contiguous from lane 0)
//   disp_entry        payload per lane (fault fields ignored)
//   disp_ready        all lanes may allocate this cycle
//   disp_rob_idx      index assigned to each lane
//   cmpl_valid        completion strobe per FU
//   cmpl_rob_idx      completing entry per FU
//   cmpl_exception    entry faulted
//   cmpl_br_mispred   branch mispredicted
//   ret_valid         retiring lanes, contiguous from lane 0
//   ret_entry         retiring entry contents with stored fault bits
//   flush             faulting entry retires this cycle
//   flush_pc          pc of that entry
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic     [DISP_WIDTH-1:0]      disp_valid,
    input  ROB_Entry [DISP_WIDTH-1:0]      disp_entry,
    output logic                           disp_ready,
    output rob_idx_t [DISP_WIDTH-1:0]      disp_rob_idx,
    input  logic     [NUM_FUS-1:0]         cmpl_valid,
    input  rob_idx_t [NUM_FUS-1:0]         cmpl_rob_idx,
    input  logic     [NUM_FUS-1:0]         cmpl_exception,
    input  logic     [NUM_FUS-1:0]         cmpl_br_mispred,
    output logic     [RETIRE_WIDTH-1:0]    ret_valid,
    output ROB_Entry [RETIRE_WIDTH-1:0]    ret_entry,
    output logic                           flush,
    output logic     [PC_W-1:0]            flush_pc
);

    rob_idx_t                head_q, head_d;
    rob_idx_t                tail_q, tail_d;
    rob_cnt_t                count_q, count_d;
    logic [NUM_ROB_ENTS-1:0] valid_q, valid_d;
    logic [NUM_ROB_ENTS-1:0] done_q, done_d;
    logic [NUM_ROB_ENTS-1:0] exc_q, exc_d;
    logic [NUM_ROB_ENTS-1:0] brm_q, brm_d;
    ROB_Entry                payload_q [NUM_ROB_ENTS];
    ROB_Entry                payload_d [NUM_ROB_ENTS];

    ret_cnt_t   n_ret;
    alloc_cnt_t n_alloc;
    ret_lane_t  flush_lane;
    rob_idx_t   flush_idx;
    rob_cnt_t   free_slots;
    ROB_Cmpl    cmpl [NUM_FUS];

    rob_retire_select u_retire_select (
        .head       (head_q),
        .ent_valid  (valid_q),
        .ent_done   (done_q),
        .ent_exc    (exc_q),
        .ent_brm    (brm_q),
        .ret_valid  (ret_valid),
        .n_ret      (n_ret),
        .flush      (flush),
        .flush_lane (flush_lane)
    );

    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            cmpl[f].valid      = cmpl_valid[f];
            cmpl[f].idx        = cmpl_rob_idx[f];
            cmpl[f].exception  = cmpl_exception[f];
            cmpl[f].br_mispred = cmpl_br_mispred[f];
        end
    end

    // Readiness uses registered occupancy only; slots retired this cycle
    // become usable on the next one.
    assign free_slots = rob_cnt_t'(NUM_ROB_ENTS) - count_q;
    assign disp_ready = (free_slots >= rob_cnt_t'(DISP_WIDTH)) && !flush;

    assign flush_idx = rob_idx_add(head_q, flush_lane);
    assign flush_pc  = flush ? payload_q[flush_idx].pc : '0;

    always_comb begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            disp_rob_idx[i] = rob_idx_add(tail_q, i);
        end
    end

    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_entry[k] = '0;
            if (ret_valid[k]) begin
                ret_entry[k]            = payload_q[rob_idx_add(head_q, k)];
                ret_entry[k].exception  = exc_q[rob_idx_add(head_q, k)];
                ret_entry[k].br_mispred = brm_q[rob_idx_add(head_q, k)];
            end
        end
    end

    always_comb begin
        n_alloc = '0;
        if (disp_ready) begin
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (disp_valid[i]) begin
                    n_alloc = n_alloc + alloc_cnt_t'(1);
                end
            end
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        done_d    = done_q;
        exc_d     = exc_q;
        brm_d     = brm_q;
        payload_d = payload_q;

        // Completions to unallocated slots are ignored; several ports naming
        // the same entry simply OR their fault bits together.
        for (int f = 0; f < NUM_FUS; f++) begin
            if (cmpl[f].valid && valid_q[cmpl[f].idx]) begin
                done_d[cmpl[f].idx] = 1'b1;
                exc_d[cmpl[f].idx]  = exc_d[cmpl[f].idx] | cmpl[f].exception;
                brm_d[cmpl[f].idx]  = brm_d[cmpl[f].idx] | cmpl[f].br_mispred;
            end
        end

        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (ret_valid[k]) begin
                valid_d[rob_idx_add(head_q, k)] = 1'b0;
                done_d[rob_idx_add(head_q, k)]  = 1'b0;
            end
        end

        // Allocation goes last so a fresh entry always starts clean, even if
        // a stale completion named the same slot this cycle.
        if (disp_ready) begin
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (disp_valid[i]) begin
                    payload_d[rob_idx_add(tail_q, i)]            = disp_entry[i];
                    payload_d[rob_idx_add(tail_q, i)].exception  = 1'b0;
                    payload_d[rob_idx_add(tail_q, i)].br_mispred = 1'b0;
                    valid_d[rob_idx_add(tail_q, i)] = 1'b1;
                    done_d[rob_idx_add(tail_q, i)]  = 1'b0;
                    exc_d[rob_idx_add(tail_q, i)]   = 1'b0;
                    brm_d[rob_idx_add(tail_q, i)]   = 1'b0;
                end
            end
        end

        head_d  = head_q + rob_idx_t'(n_ret);
        tail_d  = tail_q + rob_idx_t'(n_alloc);
        count_d = count_q + rob_cnt_t'(n_alloc) - rob_cnt_t'(n_ret);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
            brm_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            brm_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            brm_q   <= brm_d;
        end
        // Payload is qualified by valid_q, so it needs no reset.
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                          clk;
    logic                          rst;
    logic     [DISP_WIDTH-1:0]     disp_valid;
    ROB_Entry [DISP_WIDTH-1:0]     disp_entry;
    logic                          disp_ready;
    rob_idx_t [DISP_WIDTH-1:0]     disp_rob_idx;
    logic     [NUM_FUS-1:0]        cmpl_valid;
    rob_idx_t [NUM_FUS-1:0]        cmpl_rob_idx;
    logic     [NUM_FUS-1:0]        cmpl_exception;
    logic     [NUM_FUS-1:0]        cmpl_br_mispred;
    logic     [RETIRE_WIDTH-1:0]   ret_valid;
    ROB_Entry [RETIRE_WIDTH-1:0]   ret_entry;
    logic                          flush;
    logic     [PC_W-1:0]           flush_pc;

    int checks;
    int errors;

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .disp_valid      (disp_valid),
        .disp_entry      (disp_entry),
        .disp_ready      (disp_ready),
        .disp_rob_idx    (disp_rob_idx),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rob_idx    (cmpl_rob_idx),
        .cmpl_exception  (cmpl_exception),
        .cmpl_br_mispred (cmpl_br_mispred),
        .ret_valid       (ret_valid),
        .ret_entry       (ret_entry),
        .flush           (flush),
        .flush_pc        (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cmpl();
        cmpl_valid      = '0;
        cmpl_rob_idx    = '0;
        cmpl_exception  = '0;
        cmpl_br_mispred = '0;
    endtask

    task automatic clr_all();
        disp_valid = '0;
        disp_entry = '0;
        clr_cmpl();
    endtask

    task automatic disp(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        disp_valid             = v;
        disp_entry             = '0;
        disp_entry[0].pc       = pc0;
        disp_entry[0].dst_preg = pc0[8:2];
        disp_entry[0].dst_areg = pc0[6:2];
        disp_entry[1].pc       = pc1;
        disp_entry[1].dst_preg = pc1[8:2];
        disp_entry[1].dst_areg = pc1[6:2];
    endtask

    task automatic cmpl(input int f, input int idx, input logic exc, input logic brm);
        cmpl_valid[f]      = 1'b1;
        cmpl_rob_idx[f]    = rob_idx_t'(idx);
        cmpl_exception[f]  = exc;
        cmpl_br_mispred[f] = brm;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", disp_ready, 1);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_tail", disp_rob_idx[0], 0);

        // 1: fill with no completions
        for (int c = 0; c < 32; c++) begin
            disp(2'b11, 32'h1000 + 8 * c, 32'h1004 + 8 * c);
            #1;
            chk("t1_ready", disp_ready, 1);
            chk("t1_tail", disp_rob_idx[0], 2 * c);
            chk("t1_ret_valid", ret_valid, 0);
            tick();
        end
        #1;
        chk("t1_full_ready", disp_ready, 0);
        chk("t1_full_ret", ret_valid, 0);
        tick();
        clr_all();
        #1;
        chk("t1_drop_tail", disp_rob_idx[0], 0);
        chk("t1_drop_ready", disp_ready, 0);
        chk("t1_drop_ret", ret_valid, 0);

        // reset while full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rfull_ready", disp_ready, 1);
        chk("rfull_ret", ret_valid, 0);
        chk("rfull_flush", flush, 0);
        chk("rfull_flush_pc", flush_pc, 0);
        chk("rfull_tail", disp_rob_idx[0], 0);

        // 2: out-of-order completion, in-order retire
        disp(2'b11, 32'h2000, 32'h2004);
        #1;
        chk("t2_idx0", disp_rob_idx[0], 0);
        tick();
        disp(2'b11, 32'h2008, 32'h200c);
        #1;
        chk("t2_idx2", disp_rob_idx[0], 2);
        tick();
        clr_all();
        for (int n = 3; n >= 0; n--) begin
            clr_cmpl();
            cmpl(0, n, 1'b0, 1'b0);
            #1;
            chk("t2_no_ret", ret_valid, 0);
            tick();
        end
        clr_all();
        #1;
        chk("t2_ret_valid", ret_valid, 4'b1111);
        chk("t2_pc0", ret_entry[0].pc, 32'h2000);
        chk("t2_pc1", ret_entry[1].pc, 32'h2004);
        chk("t2_pc2", ret_entry[2].pc, 32'h2008);
        chk("t2_pc3", ret_entry[3].pc, 32'h200c);
        chk("t2_preg2", ret_entry[2].dst_preg, 7'h02);
        chk("t2_flush", flush, 0);
        tick();
        chk("t2_after_ret", ret_valid, 0);
        chk("t2_tail", disp_rob_idx[0], 4);
        disp(2'b01, 32'h2010, 32'h0);
        tick();
        clr_all();
        cmpl(1, 4, 1'b0, 1'b0);
        tick();
        clr_all();
        #1;
        chk("t2_head4_ret", ret_valid, 4'b0001);
        chk("t2_head4_pc", ret_entry[0].pc, 32'h2010);
        tick();

        // 3: mispredict flush
        rst = 1'b1;
        tick();
        rst = 1'b0;
        disp(2'b11, 32'h00fc, 32'h0100);
        tick();
        disp(2'b11, 32'h0104, 32'h0108);
        tick();
        disp(2'b11, 32'h010c, 32'h0110);
        tick();
        clr_all();
        cmpl(0, 2, 1'b0, 1'b0);
        cmpl(1, 3, 1'b0, 1'b0);
        cmpl(2, 4, 1'b0, 1'b0);
        cmpl(3, 5, 1'b0, 1'b0);
        #1;
        chk("t3_no_ret", ret_valid, 0);
        tick();
        clr_cmpl();
        cmpl(0, 0, 1'b0, 1'b0);
        cmpl(1, 1, 1'b0, 1'b1);
        #1;
        chk("t3_no_ret2", ret_valid, 0);
        tick();
        clr_cmpl();
        disp(2'b11, 32'h0900, 32'h0904);
        cmpl(2, 3, 1'b1, 1'b0);
        #1;
        chk("t3_ret_valid", ret_valid, 4'b0011);
        chk("t3_flush", flush, 1);
        chk("t3_flush_pc", flush_pc, 32'h100);
        chk("t3_ready", disp_ready, 0);
        chk("t3_brm1", ret_entry[1].br_mispred, 1);
        chk("t3_brm0", ret_entry[0].br_mispred, 0);
        tick();
        clr_all();
        #1;
        chk("t3_post_flush", flush, 0);
        chk("t3_post_ret", ret_valid, 0);
        chk("t3_post_ready", disp_ready, 1);
        chk("t3_post_tail", disp_rob_idx[0], 0);
        tick();
        chk("t3_never_ret", ret_valid, 0);
        disp(2'b01, 32'h0300, 32'h0);
        tick();
        clr_all();
        cmpl(0, 0, 1'b0, 1'b0);
        tick();
        clr_all();
        #1;
        chk("t3_head0_ret", ret_valid, 4'b0001);
        chk("t3_head0_pc", ret_entry[0].pc, 32'h300);
        tick();

        // 4: pointer wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 31; c++) begin
            disp(2'b11, 32'h3000 + 8 * c, 32'h3004 + 8 * c);
            tick();
        end
        clr_all();
        for (int c = 0; c < 16; c++) begin
            clr_cmpl();
            for (int f = 0; f < 4; f++) begin
                if (4 * c + f < 62) cmpl(f, 4 * c + f, 1'b0, 1'b0);
            end
            tick();
        end
        clr_all();
        tick();
        tick();
        tick();
        chk("t4_drained", ret_valid, 0);
        chk("t4_tail62", disp_rob_idx[0], 62);
        chk("t4_ready", disp_ready, 1);
        disp(2'b11, 32'h4000, 32'h4004);
        #1;
        chk("t4_idx62", disp_rob_idx[0], 62);
        chk("t4_idx63", disp_rob_idx[1], 63);
        tick();
        disp(2'b11, 32'h4008, 32'h400c);
        #1;
        chk("t4_idx0", disp_rob_idx[0], 0);
        chk("t4_idx1", disp_rob_idx[1], 1);
        tick();
        clr_all();
        cmpl(0, 1, 1'b0, 1'b0);
        cmpl(1, 62, 1'b0, 1'b0);
        cmpl(2, 0, 1'b0, 1'b0);
        cmpl(3, 63, 1'b0, 1'b0);
        #1;
        chk("t4_no_ret", ret_valid, 0);
        tick();
        clr_all();
        #1;
        chk("t4_ret_valid", ret_valid, 4'b1111);
        chk("t4_pc0", ret_entry[0].pc, 32'h4000);
        chk("t4_pc1", ret_entry[1].pc, 32'h4004);
        chk("t4_pc2", ret_entry[2].pc, 32'h4008);
        chk("t4_pc3", ret_entry[3].pc, 32'h400c);
        tick();
        chk("t4_after_ret", ret_valid, 0);
        chk("t4_tail2", disp_rob_idx[0], 2);
        disp(2'b01, 32'h4010, 32'h0);
        tick();
        clr_all();
        cmpl(3, 2, 1'b0, 1'b0);
        tick();
        clr_all();
        #1;
        chk("t4_head2_ret", ret_valid, 4'b0001);
        chk("t4_head2_pc", ret_entry[0].pc, 32'h4010);
        tick();

        // 5: retire while full, dispatch held off
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 32; c++) begin
            disp(2'b11, 32'h5000 + 8 * c, 32'h5004 + 8 * c);
            tick();
        end
        clr_all();
        for (int f = 0; f < 4; f++) cmpl(f, f, 1'b0, 1'b0);
        #1;
        chk("t5_full_ready", disp_ready, 0);
        tick();
        clr_cmpl();
        disp(2'b11, 32'h5800, 32'h5804);
        #1;
        chk("t5_ret_valid", ret_valid, 4'b1111);
        chk("t5_ready_same", disp_ready, 0);
        chk("t5_pc0", ret_entry[0].pc, 32'h5000);
        tick();
        clr_all();
        #1;
        chk("t5_ready_next", disp_ready, 1);
        chk("t5_tail", disp_rob_idx[0], 0);
        chk("t5_ret_next", ret_valid, 0);

        // 6: completion corner cases
        rst = 1'b1;
        tick();
        rst = 1'b0;
        disp(2'b11, 32'h0500, 32'h0504);
        cmpl(1, 5, 1'b0, 1'b0);
        tick();
        clr_cmpl();
        disp(2'b11, 32'h0508, 32'h050c);
        cmpl(3, 3, 1'b0, 1'b0);
        tick();
        clr_all();
        cmpl(0, 0, 1'b0, 1'b0);
        cmpl(1, 1, 1'b0, 1'b0);
        cmpl(2, 2, 1'b0, 1'b0);
        #1;
        chk("t6_no_ret", ret_valid, 0);
        tick();
        clr_all();
        #1;
        chk("t6_ret3", ret_valid, 4'b0111);
        chk("t6_flush0", flush, 0);
        tick();
        cmpl(0, 3, 1'b0, 1'b0);
        cmpl(2, 3, 1'b1, 1'b0);
        #1;
        chk("t6_wait", ret_valid, 0);
        tick();
        clr_all();
        #1;
        chk("t6_ret_exc", ret_valid, 4'b0001);
        chk("t6_flush", flush, 1);
        chk("t6_flush_pc", flush_pc, 32'h50c);
        chk("t6_exc_bit", ret_entry[0].exception, 1);
        chk("t6_pc", ret_entry[0].pc, 32'h50c);
        tick();
        chk("t6_post_flush", flush, 0);
        chk("t6_post_ready", disp_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
